// File: rtl/wb_gpio_irq_if.sv
// Wishbone classic bus bundle for the GPIO peripheral slot.
interface wb_gpio_irq_if;
  logic [2:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO with input synchronisers, atomic set/clear of outputs and
// per-pin rising/falling edge interrupts folded into one level irq.
module wb_gpio_irq #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  wb_gpio_irq_if.slave     wb,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_dir_o,
  output logic             irq_o
);

  typedef enum logic [2:0] {
    REG_IN      = 3'd0,
    REG_OUT     = 3'd1,
    REG_DIR     = 3'd2,
    REG_OUT_SET = 3'd3,
    REG_OUT_CLR = 3'd4,
    REG_RISE_EN = 3'd5,
    REG_FALL_EN = 3'd6,
    REG_PEND    = 3'd7
  } reg_addr_e;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync, prev_q;
  logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, pend_q;
  logic [WIDTH-1:0] wmask, wdata, w1c_mask, rise, fall;
  logic [31:0]      rd_data, dat_q;
  logic             ack_q, access, wr_en;
  reg_addr_e        addr;
  logic             unused_dat;

  assign addr       = reg_addr_e'(wb.wb_adr_i);
  assign access     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr_en      = access & wb.wb_we_i;
  assign sync       = sync_q[SYNC_STAGES-1];
  assign rise       = sync & ~prev_q & rise_en_q;
  assign fall       = ~sync & prev_q & fall_en_q;
  assign w1c_mask   = (wr_en && addr == REG_PEND) ? wdata : '0;
  assign unused_dat = ^wb.wb_dat_i;

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;
  assign gpio_o      = out_q;
  assign gpio_dir_o  = dir_q;

  // Byte-lane gated write data: pin i belongs to lane i/8.
  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      wmask[i] = wb.wb_sel_i[i/8];
    end
    wdata = wb.wb_dat_i[WIDTH-1:0] & wmask;
  end

  // Read mux; unused upper bits and the write-only registers read as zero.
  always_comb begin
    rd_data = '0;
    case (addr)
      REG_IN:      rd_data[WIDTH-1:0] = sync;
      REG_OUT:     rd_data[WIDTH-1:0] = out_q;
      REG_DIR:     rd_data[WIDTH-1:0] = dir_q;
      REG_OUT_SET: rd_data = '0;
      REG_OUT_CLR: rd_data = '0;
      REG_RISE_EN: rd_data[WIDTH-1:0] = rise_en_q;
      REG_FALL_EN: rd_data[WIDTH-1:0] = fall_en_q;
      REG_PEND:    rd_data[WIDTH-1:0] = pend_q;
      default:     rd_data = '0;
    endcase
  end

  // Input synchroniser chain and edge-history flop.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
      prev_q <= sync;
    end
  end

  // Single-cycle ack pulse with registered read data alongside it.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= access;
      dat_q <= access ? rd_data : '0;
    end
  end

  // Control registers, written on the ack edge.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      out_q     <= OUT_RESET;
      dir_q     <= DIR_RESET;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr_en) begin
      case (addr)
        REG_OUT:     out_q     <= (out_q & ~wmask) | wdata;
        REG_DIR:     dir_q     <= (dir_q & ~wmask) | wdata;
        REG_OUT_SET: out_q     <= out_q | wdata;
        REG_OUT_CLR: out_q     <= out_q & ~wdata;
        REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wdata;
        REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wdata;
        default: ;
      endcase
    end
  end

  // Pending edges: W1C clears, a same-cycle new edge wins.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~w1c_mask) | rise | fall;
    end
  end

  // Registered level interrupt.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |pend_q;
    end
  end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed bench for wb_gpio_irq (WIDTH=8, SYNC_STAGES=2).
module tb_wb_gpio_irq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] gpio_i = 8'h5A;
  logic [7:0] gpio_o, gpio_dir_o;
  logic       irq_o;
  int         n_checks = 0;
  int         n_pass = 0;

  wb_gpio_irq_if bus();

  wb_gpio_irq #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .OUT_RESET(8'h3C),
    .DIR_RESET(8'hC3)
  ) dut (
    .wb_clk(clk),
    .wb_rst_n(rst_n),
    .wb(bus),
    .gpio_i(gpio_i),
    .gpio_o(gpio_o),
    .gpio_dir_o(gpio_dir_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_start(input logic [2:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel);
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
  endtask

  task automatic bus_end();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.wb_ack_o && n < 8);
    check({tag, "_ack_lat"}, 32'(n), 32'd1);
  endtask

  task automatic wb_write(input string tag, input logic [2:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    bus_start(adr, 1'b1, dat, sel);
    wait_ack(tag);
    bus_end();
    tick(1);
  endtask

  task automatic wb_read(input string tag, input logic [2:0] adr, input logic [31:0] exp);
    bus_start(adr, 1'b0, 32'hDEAD_BEEF, 4'hF);
    wait_ack(tag);
    check(tag, bus.wb_dat_o, exp);
    tick(1);
    check({tag, "_ack_width"}, 32'(bus.wb_ack_o), 32'd0);
    bus_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus_end();

    // Reset state and full register map read.
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_gpio_o", 32'(gpio_o), 32'h3C);
    check("rst_dir", 32'(gpio_dir_o), 32'hC3);
    wb_read("rd_in", 3'd0, 32'h5A);
    wb_read("rd_out", 3'd1, 32'h3C);
    wb_read("rd_dir", 3'd2, 32'hC3);
    wb_read("rd_set", 3'd3, 32'h0);
    wb_read("rd_clr", 3'd4, 32'h0);
    wb_read("rd_rise", 3'd5, 32'h0);
    wb_read("rd_fall", 3'd6, 32'h0);
    wb_read("rd_pend", 3'd7, 32'h0);

    // OUT write, atomic set/clear and byte-lane gating.
    wb_write("wr_out", 3'd1, 32'hA5, 4'hF);
    check("out_a5", 32'(gpio_o), 32'hA5);
    wb_write("wr_set", 3'd3, 32'h0F, 4'hF);
    check("out_af", 32'(gpio_o), 32'hAF);
    wb_write("wr_clr", 3'd4, 32'h81, 4'hF);
    check("out_2e", 32'(gpio_o), 32'h2E);
    wb_write("wr_out_sel0", 3'd1, 32'hFF, 4'h0);
    check("out_sel0", 32'(gpio_o), 32'h2E);
    wb_write("wr_dir", 3'd2, 32'h55, 4'h1);
    check("dir_55", 32'(gpio_dir_o), 32'h55);
    wb_write("wr_dir_hi", 3'd2, 32'hFFFF_FF00, 4'hE);
    check("dir_hi_lanes", 32'(gpio_dir_o), 32'h55);
    wb_write("wr_in", 3'd0, 32'hFF, 4'hF);
    wb_read("rd_out2", 3'd1, 32'h2E);

    // Rising edge latency: PEND at 3 edges, irq one edge later.
    gpio_i = 8'h00;
    tick(5);
    wb_write("wr_rise", 3'd5, 32'h01, 4'hF);
    gpio_i[0] = 1'b1;
    tick(2);
    check("irq_e2", 32'(irq_o), 32'd0);
    tick(1);
    check("irq_e3", 32'(irq_o), 32'd0);
    tick(1);
    check("irq_e4", 32'(irq_o), 32'd1);
    wb_read("rd_pend_rise", 3'd7, 32'h01);
    gpio_i[0] = 1'b0;
    tick(6);
    wb_read("rd_pend_nofall", 3'd7, 32'h01);

    // W1C coinciding with a new rising edge: set wins.
    gpio_i[0] = 1'b1;
    tick(2);
    bus_start(3'd7, 1'b1, 32'h01, 4'h1);
    wait_ack("w1c_race");
    bus_end();
    check("race_irq0", 32'(irq_o), 32'd1);
    tick(1);
    check("race_irq1", 32'(irq_o), 32'd1);
    wb_read("rd_pend_race", 3'd7, 32'h01);

    // Plain W1C: irq drops one cycle after PEND clears.
    bus_start(3'd7, 1'b1, 32'h01, 4'h1);
    wait_ack("w1c_clr");
    bus_end();
    check("clr_irq0", 32'(irq_o), 32'd1);
    tick(1);
    check("clr_irq1", 32'(irq_o), 32'd0);
    wb_read("rd_pend_clr", 3'd7, 32'h00);

    // Falling edges on all pins retained after enables drop.
    wb_write("wr_fall", 3'd6, 32'hFF, 4'hF);
    gpio_i = 8'hFF;
    tick(6);
    gpio_i = 8'h00;
    tick(6);
    check("fall_irq", 32'(irq_o), 32'd1);
    wb_write("wr_rise0", 3'd5, 32'h00, 4'hF);
    wb_write("wr_fall0", 3'd6, 32'h00, 4'hF);
    wb_read("rd_pend_ff", 3'd7, 32'hFF);
    wb_read("rd_fall0", 3'd6, 32'h00);
    wb_write("w1c_sel_off", 3'd7, 32'hFF, 4'h2);
    wb_read("rd_pend_ff2", 3'd7, 32'hFF);
    wb_write("w1c_f0", 3'd7, 32'hF0, 4'hF);
    wb_read("rd_pend_0f", 3'd7, 32'h0F);

    // Reset between strobe and ack.
    bus_start(3'd1, 1'b1, 32'h11, 4'hF);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("mid_rst_irq", 32'(irq_o), 32'd0);
    check("mid_rst_out", 32'(gpio_o), 32'h3C);
    check("mid_rst_dir", 32'(gpio_dir_o), 32'hC3);
    @(posedge clk);
    #1;
    check("mid_rst_ack2", 32'(bus.wb_ack_o), 32'd0);
    bus_end();
    tick(1);
    rst_n = 1'b1;
    tick(4);
    wb_read("post_out", 3'd1, 32'h3C);
    wb_read("post_dir", 3'd2, 32'hC3);
    wb_read("post_rise", 3'd5, 32'h00);
    wb_read("post_pend", 3'd7, 32'h00);
    wb_read("post_in", 3'd0, 32'h00);
    check("post_irq", 32'(irq_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
- Parametrised successor to the fixed 8-bit gpio peripheral.
- Wishbone classic slave with WIDTH pins, input synchronisers, atomic set/clear of outputs, and per-pin rising/falling-edge interrupts.
- Drives one level interrupt output to the CPU interrupt controller.
- Sits on the SoC Wishbone intercon beside uart0, in the peripheral slot.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32).
- SYNC_STAGES, 2, flip-flop stages on gpio_i before use (2..4).
- OUT_RESET, 0, reset value of the OUT register (WIDTH bits).
- DIR_RESET, 0, reset value of the DIR register (1 = output).

Ports:
- wb_clk  in  1  system clock.
- wb_rst_n  in  1  asynchronous active-low reset.
- wb_adr_i  in  3  word address, taken from bus address bits [4:2].
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lane enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  tied 0.
- wb_rty_o  out  1  tied 0.
- gpio_i  in  WIDTH  pad inputs, asynchronous.
- gpio_o  out  WIDTH  pad outputs (= OUT).
- gpio_dir_o  out  WIDTH  pad output enables (= DIR).
- irq_o  out  1  interrupt, level, active high.

Behaviour:
- Reset (wb_rst_n low, asynchronous):
  - OUT=OUT_RESET, DIR=DIR_RESET.
  - RISE_EN, FALL_EN, PEND, all synchroniser flops and the edge-history flop clear to 0.
  - wb_ack_o=0, wb_dat_o=0, irq_o=0.
  - Reset during a bus cycle drops ack; the master must restart the access.
- Register map (wb_adr_i):
  - 0 IN: RO, synchronised input.
  - 1 OUT: RW.
  - 2 DIR: RW.
  - 3 OUT_SET: WO, write 1s to set OUT bits.
  - 4 OUT_CLR: WO, write 1s to clear OUT bits.
  - 5 RISE_EN: RW.
  - 6 FALL_EN: RW.
  - 7 PEND: read; write 1 to clear (W1C).
- Read-data rules: bits [31:WIDTH] read 0. OUT_SET and OUT_CLR read 0.
- Handshake:
  - wb_ack_o <= cyc & stb & ~wb_ack_o, giving a one-cycle pulse with latency 1.
  - Back-to-back accesses complete every second cycle.
  - Writes take effect on the ack edge.
  - wb_dat_o is registered alongside ack and is valid only while ack is high.
- Byte lanes: wb_sel_i[n] gates bits [8n+7:8n] on every writable register, including SET, CLR and W1C. Writes to IN are ignored.
- Synchroniser: gpio_i passes through SYNC_STAGES flops to give sync. A history flop prev <= sync.
  - rise = sync & ~prev & RISE_EN.
  - fall = ~sync & prev & FALL_EN.
  - Edge latency: an input change appears in PEND SYNC_STAGES+1 cycles after the first sampling edge.
- PEND update per cycle: PEND <= (PEND & ~w1c_mask) | rise | fall.
  - A new edge in the same cycle as W1C of that bit leaves the bit set; set wins.
- Edges are detected regardless of DIR, so output pins fed back can interrupt.
- Enable changes: disabling RISE_EN/FALL_EN does not clear PEND; PEND is cleared only by W1C or reset.
- irq_o is registered: irq_o <= |PEND. It deasserts one cycle after the last pending bit is cleared.
- OUT_SET and OUT_CLR only: with the same bit set in both within one access, the access is to a single register, so no conflict arises.

Test Plan:
- Reset, then read all 8 addresses → IN = sync(gpio_i), OUT=OUT_RESET, DIR=DIR_RESET, others 0; irq_o=0; each ack exactly one cycle wide, 1 cycle after stb.
- Write OUT=0xA5, write OUT_SET=0x0F, then write OUT_CLR=0x81 → gpio_o sequence 0xA5, 0xAF, 0x2E; a write with sel=4'b0000 leaves OUT unchanged.
- RISE_EN=0x01, then gpio_i[0] 0→1 → PEND=0x01 at SYNC_STAGES+1 cycles, irq_o high 1 cycle later; a 1→0 edge with FALL_EN=0 adds nothing.
- PEND=0x01; write PEND=0x01 in the same cycle a new rising edge on bit 0 is detected → PEND stays 0x01 and irq_o stays high; repeat without the edge → PEND=0, irq_o low the next cycle.
- FALL_EN=0xFF, drive all pins 0xFF→0x00, then write RISE_EN=0 and FALL_EN=0 → PEND=0xFF retained; W1C 0xF0 → PEND=0x0F.
- Assert wb_rst_n low mid-write, between stb and ack → no ack, all registers at reset values, irq_o=0 asynchronously.
